// File: rtl/ccff_chain_loader_if.sv
// Bitstream-in / readback-out handshake bundle between a bitstream source and the chain loader.
interface ccff_chain_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] rb_data;
    logic              rb_valid;
    logic              rb_ready;

    modport master (
        output cfg_data, cfg_valid, rb_ready,
        input  cfg_ready, rb_data, rb_valid
    );

    modport slave (
        input  cfg_data, cfg_valid, rb_ready,
        output cfg_ready, rb_data, rb_valid
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first into a ccff chain and returns the displaced bits as readback words.
// Handshake to first shift 1 cycle, last shift to rb_valid 1 cycle; cfg/rb stalls freeze the chain with no loss.
module ccff_chain_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 prog_clock,
    input  logic                 prog_reset,
    input  logic                 start,
    ccff_chain_loader_if.slave   bus,
    output logic                 config_enable,
    output logic                 ccff_head,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done
);
    localparam int NB_W = $clog2(DATA_W + 1);
    localparam int W    = (CNT_W > NB_W) ? CNT_W : NB_W;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, RB, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  bits_left;
    logic [NB_W-1:0]   sh_cnt;
    logic [NB_W-1:0]   nb;
    logic [DATA_W-1:0] word_sr;
    logic [DATA_W-1:0] rb_mask;
    logic [DATA_W-1:0] rb_data_q;
    logic              cfg_ready_q;
    logic              rb_valid_q;
    logic              cfg_fire;
    logic              rb_fire;

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.rb_valid  = rb_valid_q;
    assign bus.rb_data   = rb_data_q;

    assign cfg_fire = bus.cfg_valid & cfg_ready_q;
    assign rb_fire  = rb_valid_q & bus.rb_ready;

    // Bits taken from the current word: a full word, or only what the chain still needs.
    always_comb begin
        nb = NB_W'(DATA_W);
        if (W'(bits_left) < W'(DATA_W)) begin
            nb = NB_W'(bits_left);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: if (cfg_fire) state_nx = SHIFT;
            SHIFT: if (sh_cnt == NB_W'(1)) state_nx = RB;
            RB:    if (rb_fire) state_nx = (bits_left == '0) ? DONE : FETCH;
            DONE:  state_nx = start ? FETCH : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge prog_clock) begin
        if (prog_reset) begin
            state         <= IDLE;
            bits_left     <= '0;
            sh_cnt        <= '0;
            word_sr       <= '0;
            rb_mask       <= '0;
            rb_data_q     <= '0;
            cfg_ready_q   <= 1'b0;
            rb_valid_q    <= 1'b0;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            // Ready is derived from the settled FETCH state, so it rises one cycle after entry.
            cfg_ready_q   <= (state == FETCH) && !cfg_fire;
            rb_valid_q    <= (state_nx == RB);
            config_enable <= (state_nx == SHIFT);
            busy          <= (state_nx == FETCH) || (state_nx == SHIFT) || (state_nx == RB);
            done          <= (state_nx == DONE);

            if (((state == IDLE) || (state == DONE)) && start) begin
                bits_left <= CNT_W'(CHAIN_LEN);
            end

            if (cfg_fire) begin
                bits_left <= bits_left - CNT_W'(nb);
                sh_cnt    <= nb;
                ccff_head <= bus.cfg_data[DATA_W-1];
                word_sr   <= bus.cfg_data << 1;
                rb_mask   <= {1'b1, {(DATA_W-1){1'b0}}};
                rb_data_q <= '0;
            end else if (state == SHIFT) begin
                // Tail is sampled before this edge's shift; the mask places it left-justified.
                sh_cnt    <= sh_cnt - NB_W'(1);
                ccff_head <= word_sr[DATA_W-1];
                word_sr   <= word_sr << 1;
                rb_mask   <= rb_mask >> 1;
                if (ccff_tail) begin
                    rb_data_q <= rb_data_q | rb_mask;
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: two loaders (16-bit and 12-bit chains) each feeding a behavioural shift-register chain.
module tb_ccff_chain_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16, start16, ce16, head16, tail16, busy16, done16;
    logic rst12, start12, ce12, head12, tail12, busy12, done12;

    ccff_chain_loader_if #(.DATA_W(8)) b16 ();
    ccff_chain_loader_if #(.DATA_W(8)) b12 ();

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(16)) u16 (
        .prog_clock(clk), .prog_reset(rst16), .start(start16), .bus(b16.slave),
        .config_enable(ce16), .ccff_head(head16), .ccff_tail(tail16),
        .busy(busy16), .done(done16)
    );

    ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(12)) u12 (
        .prog_clock(clk), .prog_reset(rst12), .start(start12), .bus(b12.slave),
        .config_enable(ce12), .ccff_head(head12), .ccff_tail(tail12),
        .busy(busy12), .done(done12)
    );

    // Chain models plus monotonic event counters (tasks take deltas, never clear them).
    logic [15:0] chain16 = '0;
    logic [11:0] chain12 = '0;
    logic [31:0] hlog16  = '0;
    logic [31:0] hlog12  = '0;
    int n_en16 = 0, n_en12 = 0, n_done16 = 0, n_done12 = 0;

    assign tail16 = chain16[15];
    assign tail12 = chain12[11];

    always @(posedge clk) begin
        if (ce16 === 1'b1) begin
            chain16 <= {chain16[14:0], head16};
            hlog16  <= {hlog16[30:0], head16};
            n_en16  <= n_en16 + 1;
        end
        if (ce12 === 1'b1) begin
            chain12 <= {chain12[10:0], head12};
            hlog12  <= {hlog12[30:0], head12};
            n_en12  <= n_en12 + 1;
        end
        if (done16 === 1'b1) n_done16 <= n_done16 + 1;
        if (done12 === 1'b1) n_done12 <= n_done12 + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Runs one two-word load on the selected DUT, inserting the requested stalls.
    task automatic run_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                            input int rb_stall, input int cfg_gap, input bit mid_start,
                            output logic [7:0] rb0, output logic [7:0] rb1,
                            output int cycles, output int stall_en, output bit ok);
        logic [7:0] words [2];
        logic [7:0] rbd, d;
        int  widx, rbn, gap_left, stall_left, en0;
        bit  fin, rdy, rvld, ce, dn, v, r, st;
        words[0] = w0; words[1] = w1;
        widx = 0; rbn = 0; gap_left = cfg_gap; stall_left = rb_stall;
        stall_en = 0; fin = 1'b0; rb0 = '0; rb1 = '0; cycles = 0; d = '0;
        en0 = sel ? n_en12 : n_en16;
        @(negedge clk);
        if (sel) start12 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        if (sel) start12 = 1'b0; else start16 = 1'b0;
        for (int k = 1; k < 400 && !fin; k++) begin
            rdy  = sel ? b12.cfg_ready : b16.cfg_ready;
            rvld = sel ? b12.rb_valid  : b16.rb_valid;
            rbd  = sel ? b12.rb_data   : b16.rb_data;
            ce   = sel ? ce12 : ce16;
            dn   = sel ? done12 : done16;
            v = 1'b0; r = 1'b0; st = 1'b0;
            if (ce && (rdy || rvld)) stall_en++;
            if (dn) begin
                fin = 1'b1;
                cycles = k + 1;
            end else begin
                if (rdy && widx < 2) begin
                    if (widx == 1 && gap_left > 0) gap_left--;
                    else begin
                        d = words[widx];
                        v = 1'b1;
                        widx++;
                    end
                end
                if (rvld) begin
                    if (rbn == 0 && stall_left > 0) stall_left--;
                    else begin
                        if (rbn == 0) rb0 = rbd; else rb1 = rbd;
                        r = 1'b1;
                        rbn++;
                    end
                end
                st = mid_start && ce && (((sel ? n_en12 : n_en16) - en0) == 3);
            end
            if (sel) begin
                b12.cfg_data = d; b12.cfg_valid = v; b12.rb_ready = r; start12 = st;
            end else begin
                b16.cfg_data = d; b16.cfg_valid = v; b16.rb_ready = r; start16 = st;
            end
            @(negedge clk);
        end
        b16.cfg_valid = 1'b0; b16.rb_ready = 1'b0; start16 = 1'b0;
        b12.cfg_valid = 1'b0; b12.rb_ready = 1'b0; start12 = 1'b0;
        ok = fin;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst16 = 1'b1; rst12 = 1'b1;
        start16 = 1'b1; start12 = 1'b1;
        b16.cfg_valid = 1'b0; b16.rb_ready = 1'b0; b16.cfg_data = '0;
        b12.cfg_valid = 1'b0; b12.rb_ready = 1'b0; b12.cfg_data = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy16, done16, ce16, head16, b16.cfg_ready, b16.rb_valid, b16.rb_data} !== 14'h0)
            $display("FAIL reset16: got %h want 0", {busy16, done16, ce16, head16, b16.cfg_ready, b16.rb_valid, b16.rb_data});
        else n_pass++;
        n_total++;
        if ({busy12, done12, ce12, head12, b12.cfg_ready, b12.rb_valid, b12.rb_data} !== 14'h0)
            $display("FAIL reset12: got %h want 0", {busy12, done12, ce12, head12, b12.cfg_ready, b12.rb_valid, b12.rb_data});
        else n_pass++;
        rst16 = 1'b0; rst12 = 1'b0; start16 = 1'b0; start12 = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy16, b16.cfg_ready} !== 2'b00) $display("FAIL start_under_reset: got busy/ready %b want 00", {busy16, b16.cfg_ready});
        else n_pass++;
    endtask

    task automatic test_load;
        logic [7:0] r0, r1; int cyc, se, e0, d0; bit ok;
        e0 = n_en16; d0 = n_done16;
        run_load(1'b0, 8'hA5, 8'h3C, 0, 0, 1'b0, r0, r1, cyc, se, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL load_timeout: got %b want 1", ok); else n_pass++;
        n_total++; if (hlog16[15:0] !== 16'hA53C) $display("FAIL load_head_seq: got %h want a53c", hlog16[15:0]); else n_pass++;
        n_total++; if (n_en16 - e0 !== 16) $display("FAIL load_enables: got %0d want 16", n_en16 - e0); else n_pass++;
        n_total++; if (n_done16 - d0 !== 1) $display("FAIL load_done: got %0d want 1", n_done16 - d0); else n_pass++;
        n_total++; if (cyc !== 24) $display("FAIL load_cycles: got %0d want 24", cyc); else n_pass++;
        n_total++; if (chain16 !== 16'hA53C) $display("FAIL load_chain: got %h want a53c", chain16); else n_pass++;
        n_total++; if ({busy16, b16.cfg_ready, ce16} !== 3'b000) $display("FAIL load_idle: got %b want 000", {busy16, b16.cfg_ready, ce16}); else n_pass++;
    endtask

    task automatic test_reload;
        logic [7:0] r0, r1; int cyc, se, e0; bit ok;
        e0 = n_en16;
        run_load(1'b0, 8'hFF, 8'h00, 0, 0, 1'b0, r0, r1, cyc, se, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL reload_timeout: got %b want 1", ok); else n_pass++;
        n_total++; if (r0 !== 8'hA5) $display("FAIL reload_rb0: got %h want a5", r0); else n_pass++;
        n_total++; if (r1 !== 8'h3C) $display("FAIL reload_rb1: got %h want 3c", r1); else n_pass++;
        n_total++; if (chain16 !== 16'hFF00) $display("FAIL reload_chain: got %h want ff00", chain16); else n_pass++;
        n_total++; if (n_en16 - e0 !== 16) $display("FAIL reload_enables: got %0d want 16", n_en16 - e0); else n_pass++;
    endtask

    task automatic test_stalls;
        logic [7:0] r0, r1; int cyc, se, e0, d0; bit ok;
        e0 = n_en16; d0 = n_done16;
        run_load(1'b0, 8'hA5, 8'h3C, 10, 5, 1'b0, r0, r1, cyc, se, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL stall_timeout: got %b want 1", ok); else n_pass++;
        n_total++; if (se !== 0) $display("FAIL stall_enable: got %0d enables during stalls want 0", se); else n_pass++;
        n_total++; if (n_en16 - e0 !== 16) $display("FAIL stall_enables: got %0d want 16", n_en16 - e0); else n_pass++;
        n_total++; if (cyc !== 39) $display("FAIL stall_cycles: got %0d want 39", cyc); else n_pass++;
        n_total++; if ({r0, r1} !== 16'hFF00) $display("FAIL stall_rb: got %h want ff00", {r0, r1}); else n_pass++;
        n_total++; if (chain16 !== 16'hA53C) $display("FAIL stall_chain: got %h want a53c", chain16); else n_pass++;
        n_total++; if (n_done16 - d0 !== 1) $display("FAIL stall_done: got %0d want 1", n_done16 - d0); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] r0, r1; int cyc, se, e0, d0; bit ok;
        e0 = n_en16; d0 = n_done16;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        for (int k = 0; k < 60 && (n_en16 - e0) < 5; k++) begin
            b16.cfg_data  = 8'h96;
            b16.cfg_valid = b16.cfg_ready;
            @(negedge clk);
        end
        b16.cfg_valid = 1'b0;
        n_total++; if (n_en16 - e0 !== 5) $display("FAIL rstmid_shifts: got %0d want 5", n_en16 - e0); else n_pass++;
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        n_total++;
        if ({busy16, ce16, b16.rb_valid, done16} !== 4'b0000)
            $display("FAIL rstmid_outputs: got %b want 0000", {busy16, ce16, b16.rb_valid, done16});
        else n_pass++;
        repeat (4) @(negedge clk);
        n_total++; if (n_done16 - d0 !== 0) $display("FAIL rstmid_nodone: got %0d want 0", n_done16 - d0); else n_pass++;
        e0 = n_en16; d0 = n_done16;
        run_load(1'b0, 8'hA5, 8'h3C, 0, 0, 1'b0, r0, r1, cyc, se, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rstmid_timeout: got %b want 1", ok); else n_pass++;
        n_total++; if (n_en16 - e0 !== 16) $display("FAIL rstmid_enables: got %0d want 16", n_en16 - e0); else n_pass++;
        n_total++; if (chain16 !== 16'hA53C) $display("FAIL rstmid_chain: got %h want a53c", chain16); else n_pass++;
        n_total++; if (n_done16 - d0 !== 1) $display("FAIL rstmid_done: got %0d want 1", n_done16 - d0); else n_pass++;
    endtask

    task automatic test_start_busy;
        logic [7:0] r0, r1; int cyc, se, e0, d0; bit ok;
        e0 = n_en16; d0 = n_done16;
        run_load(1'b0, 8'h5A, 8'hC3, 0, 0, 1'b1, r0, r1, cyc, se, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL busy_timeout: got %b want 1", ok); else n_pass++;
        n_total++; if (n_en16 - e0 !== 16) $display("FAIL busy_enables: got %0d want 16", n_en16 - e0); else n_pass++;
        n_total++; if (n_done16 - d0 !== 1) $display("FAIL busy_done: got %0d want 1", n_done16 - d0); else n_pass++;
        n_total++; if (cyc !== 24) $display("FAIL busy_cycles: got %0d want 24", cyc); else n_pass++;
        n_total++; if ({r0, r1} !== 16'hA53C) $display("FAIL busy_rb: got %h want a53c", {r0, r1}); else n_pass++;
        n_total++; if (chain16 !== 16'h5AC3) $display("FAIL busy_chain: got %h want 5ac3", chain16); else n_pass++;
    endtask

    task automatic test_partial;
        logic [7:0] r0, r1; int cyc, se, e0, d0; bit ok;
        run_load(1'b1, 8'hFF, 8'hFF, 0, 0, 1'b0, r0, r1, cyc, se, ok);
        n_total++; if (chain12 !== 12'hFFF) $display("FAIL part_preload: got %h want fff", chain12); else n_pass++;
        e0 = n_en12; d0 = n_done12;
        run_load(1'b1, 8'hAB, 8'hCD, 0, 0, 1'b0, r0, r1, cyc, se, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL part_timeout: got %b want 1", ok); else n_pass++;
        n_total++; if (hlog12[11:0] !== 12'hABC) $display("FAIL part_head_seq: got %h want abc", hlog12[11:0]); else n_pass++;
        n_total++; if (n_en12 - e0 !== 12) $display("FAIL part_enables: got %0d want 12", n_en12 - e0); else n_pass++;
        n_total++; if (r0 !== 8'hFF) $display("FAIL part_rb0: got %h want ff", r0); else n_pass++;
        n_total++; if (r1 !== 8'hF0) $display("FAIL part_rb1: got %h want f0", r1); else n_pass++;
        n_total++; if (chain12 !== 12'hABC) $display("FAIL part_chain: got %h want abc", chain12); else n_pass++;
        n_total++; if (cyc !== 20) $display("FAIL part_cycles: got %0d want 20", cyc); else n_pass++;
        n_total++; if (n_done12 - d0 !== 1) $display("FAIL part_done: got %0d want 1", n_done12 - d0); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_reload();
        test_stalls();
        test_reset_mid();
        test_start_busy();
        test_partial();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
